sram_arb_rr: RTL and testbench

Round-robin SRAM arbiter with registered outputs, connecting NUM_MASTERS Avalon-MM slave ports to one asynchronous external SRAM (ce/oe/we/be, shared bidirectional data bus). It replaces the single-select two-master multiplexer: arbitration happens in hardware, and the SRAM access length is set by a programmable wait count. It sits between the SOPC bus, the test runner and any further SRAM clients, and the SRAM pins.

---
 rtl/sram_arb_rr_if.sv | 62 ++++++
 rtl/sram_arb_rr.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_sram_arb_rr.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_rr_if.sv
// ---------------------------------------------------------------------------
// sram_arb_rr_if
// Bundle of the per-master Avalon-MM request/response signals that feed the
// round-robin SRAM arbiter. Every vector packs one slice per master, with
// master i occupying slice i.
//
// Signals:
//   m_address      per-master word address       (NUM_MASTERS*ADDR_WIDTH)
//   m_byteenable   per-master byte enables       (NUM_MASTERS*BE_WIDTH)
//   m_read         per-master read strobe        (NUM_MASTERS)
//   m_write        per-master write strobe       (NUM_MASTERS)
//   m_writedata    per-master write data         (NUM_MASTERS*DATA_WIDTH)
//   m_readdata     shared read data, replicated  (NUM_MASTERS*DATA_WIDTH)
//   m_waitrequest  per-master waitrequest        (NUM_MASTERS)
//   m_lock         per-master bus lock           (NUM_MASTERS, only when
//                                                 SRAM_ARB_LOCK_EN is defined)
//
// Modports:
//   master  the request side (drives requests, receives responses)
//   slave   the arbiter side
// ---------------------------------------------------------------------------
interface sram_arb_rr_if #(
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int BE_WIDTH    = DATA_WIDTH / 8,
   parameter int NUM_MASTERS = 2
);

   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address;
   logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable;
   logic [NUM_MASTERS-1:0]            m_read;
   logic [NUM_MASTERS-1:0]            m_write;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_readdata;
   logic [NUM_MASTERS-1:0]            m_waitrequest;
`ifdef SRAM_ARB_LOCK_EN
   logic [NUM_MASTERS-1:0]            m_lock;
`endif

`ifdef SRAM_ARB_LOCK_EN
   modport master (
      output m_address, m_byteenable, m_read, m_write, m_writedata, m_lock,
      input  m_readdata, m_waitrequest
   );

   modport slave (
      input  m_address, m_byteenable, m_read, m_write, m_writedata, m_lock,
      output m_readdata, m_waitrequest
   );
`else
   modport master (
      output m_address, m_byteenable, m_read, m_write, m_writedata,
      input  m_readdata, m_waitrequest
   );

   modport slave (
      input  m_address, m_byteenable, m_read, m_write, m_writedata,
      output m_readdata, m_waitrequest
   );
`endif

endinterface

// File: rtl/sram_arb_rr.sv
// ---------------------------------------------------------------------------
// sram_arb_rr
// Round-robin arbiter giving NUM_MASTERS Avalon-MM slave ports shared access
// to one asynchronous external SRAM. Every SRAM pin is driven from a flop.
// A transaction is IDLE (arbitrate) -> ACCESS (WAIT_CYCLES+1 cycles of
// strobe) -> DONE (one-cycle acknowledge), and the following IDLE cycle is
// the bus turnaround before the next access.
//
// Ports:
//   clock          single clock domain
//   reset          asynchronous, active-high reset
//   bus            sram_arb_rr_if.slave, per-master request/response bundle
//   sram_address   registered SRAM word address
//   sram_data      bidirectional SRAM data, driven only for writes
//   sram_ce_n      registered chip enable, active low
//   sram_oe_n      registered output enable, active low
//   sram_we_n      registered write enable, active low
//   sram_be_n      registered byte selects, active low
//
// Optional feature:
//   SRAM_ARB_LOCK_EN  when defined, bus.m_lock lets the granted master keep
//                     the SRAM for consecutive transactions.
// ---------------------------------------------------------------------------
module sram_arb_rr #(
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int BE_WIDTH    = DATA_WIDTH / 8,
   parameter int NUM_MASTERS = 2,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   sram_arb_rr_if.slave          bus,
   output logic [ADDR_WIDTH-1:0] sram_address,
   inout  wire  [DATA_WIDTH-1:0] sram_data,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic [BE_WIDTH-1:0]   sram_be_n
);

   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [PTR_W:0] NUM_M = (PTR_W + 1)'(NUM_MASTERS);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t state, state_next;

   logic [CNT_W-1:0]       count, count_d;
   logic [PTR_W-1:0]       grant, grant_d;
   logic [PTR_W-1:0]       rr_ptr, rr_ptr_d;
   logic                   op_write, op_write_d;
   logic                   data_oe, data_oe_d;
   logic [DATA_WIDTH-1:0]  wdata, wdata_d;
   logic [DATA_WIDTH-1:0]  readdata, readdata_d;
   logic [NUM_MASTERS-1:0] waitreq, waitreq_d;
   logic [ADDR_WIDTH-1:0]  address_d;
   logic                   ce_n_d, oe_n_d, we_n_d;
   logic [BE_WIDTH-1:0]    be_n_d;

   logic [NUM_MASTERS-1:0] req;
   logic [PTR_W-1:0]       start;
   logic [PTR_W-1:0]       winner;
   logic [PTR_W:0]         arb_sum;
   logic                   found;
   logic [ADDR_WIDTH-1:0]  sel_address;
   logic [BE_WIDTH-1:0]    sel_be;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   logic                   sel_write;

`ifdef SRAM_ARB_LOCK_EN
   logic lock_held, lock_held_d;
   logic lock_release;
`endif

   // Pointer increment that wraps at NUM_MASTERS, which need not be a power
   // of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      logic [PTR_W:0] sum;
      sum = {1'b0, ptr} + (PTR_W + 1)'(1);
      if (sum >= NUM_M) begin
         sum = '0;
      end
      return sum[PTR_W-1:0];
   endfunction

   // Round-robin selection: scan from rr_ptr upward with wraparound and take
   // the first master that is requesting. A locking master that still holds
   // its lock masks everyone else; once it lets go, the scan starts just past
   // it so the lock does not cost the other masters their turn.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         req[i] = bus.m_read[i] | bus.m_write[i];
      end
      start = rr_ptr;
`ifdef SRAM_ARB_LOCK_EN
      lock_release = 1'b0;
      if (lock_held) begin
         if (bus.m_lock[rr_ptr]) begin
            req = req & (NUM_MASTERS'(1) << rr_ptr);
         end else begin
            lock_release = 1'b1;
            start        = next_ptr(rr_ptr);
         end
      end
`endif
      found   = 1'b0;
      winner  = '0;
      arb_sum = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         arb_sum = {1'b0, start} + (PTR_W + 1)'(k);
         if (arb_sum >= NUM_M) begin
            arb_sum = arb_sum - NUM_M;
         end
         if (!found && req[arb_sum[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = arb_sum[PTR_W-1:0];
         end
      end
   end

   // Pull the winning master's request fields out of the packed vectors.
   // A simultaneous read and write is treated as a write.
   always_comb begin
      sel_address = '0;
      sel_be      = '0;
      sel_wdata   = '0;
      sel_write   = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (winner == PTR_W'(i)) begin
            sel_address = bus.m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_be      = bus.m_byteenable[i*BE_WIDTH +: BE_WIDTH];
            sel_wdata   = bus.m_writedata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_write   = bus.m_write[i];
         end
      end
   end

   // FSM state register; reset aborts any access in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic. The access counter reaching zero marks the last
   // strobe cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = ACCESS;
         ACCESS:  if (count == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM output logic. Everything here is the next value of a flop, so the
   // SRAM pins change one cycle after the decision that drives them: the
   // IDLE grant turns the strobes on for the first ACCESS cycle, and the
   // last ACCESS cycle turns them off and raises the acknowledge for DONE.
   // Write data is left enabled through DONE for hold time and released on
   // the way back to IDLE.
   always_comb begin
      state_next_outputs_default: begin
         count_d    = count;
         grant_d    = grant;
         rr_ptr_d   = rr_ptr;
         op_write_d = op_write;
         data_oe_d  = data_oe;
         wdata_d    = wdata;
         readdata_d = readdata;
         waitreq_d  = waitreq;
         address_d  = sram_address;
         ce_n_d     = sram_ce_n;
         oe_n_d     = sram_oe_n;
         we_n_d     = sram_we_n;
         be_n_d     = sram_be_n;
`ifdef SRAM_ARB_LOCK_EN
         lock_held_d = lock_held;
`endif
      end
      case (state)
         IDLE: begin
            waitreq_d = '1;
            data_oe_d = 1'b0;
`ifdef SRAM_ARB_LOCK_EN
            if (lock_release) begin
               lock_held_d = 1'b0;
               rr_ptr_d    = next_ptr(rr_ptr);
            end
`endif
            if (found) begin
               count_d    = CNT_W'(WAIT_CYCLES);
               grant_d    = winner;
               op_write_d = sel_write;
               wdata_d    = sel_wdata;
               address_d  = sel_address;
               ce_n_d     = 1'b0;
               oe_n_d     = sel_write;
               we_n_d     = ~sel_write;
               be_n_d     = ~sel_be;
               data_oe_d  = sel_write;
            end
         end
         ACCESS: begin
            if (count == '0) begin
               ce_n_d    = 1'b1;
               oe_n_d    = 1'b1;
               we_n_d    = 1'b1;
               be_n_d    = '1;
               waitreq_d = ~(NUM_MASTERS'(1) << grant);
               if (!op_write) begin
                  readdata_d = sram_data;
               end
            end else begin
               count_d = count - CNT_W'(1);
            end
         end
         DONE: begin
            waitreq_d = '1;
            data_oe_d = 1'b0;
            rr_ptr_d  = next_ptr(grant);
`ifdef SRAM_ARB_LOCK_EN
            lock_held_d = 1'b0;
            if (bus.m_lock[grant]) begin
               rr_ptr_d    = grant;
               lock_held_d = 1'b1;
            end
`endif
         end
         default: begin
            waitreq_d = '1;
            data_oe_d = 1'b0;
         end
      endcase
   end

   // Datapath and pin registers. Reset returns the SRAM to deselected with
   // the data bus released and no master acknowledged.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count        <= '0;
         grant        <= '0;
         rr_ptr       <= '0;
         op_write     <= 1'b0;
         data_oe      <= 1'b0;
         wdata        <= '0;
         readdata     <= '0;
         waitreq      <= '1;
         sram_address <= '0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_be_n    <= '1;
`ifdef SRAM_ARB_LOCK_EN
         lock_held    <= 1'b0;
`endif
      end else begin
         count        <= count_d;
         grant        <= grant_d;
         rr_ptr       <= rr_ptr_d;
         op_write     <= op_write_d;
         data_oe      <= data_oe_d;
         wdata        <= wdata_d;
         readdata     <= readdata_d;
         waitreq      <= waitreq_d;
         sram_address <= address_d;
         sram_ce_n    <= ce_n_d;
         sram_oe_n    <= oe_n_d;
         sram_we_n    <= we_n_d;
         sram_be_n    <= be_n_d;
`ifdef SRAM_ARB_LOCK_EN
         lock_held    <= lock_held_d;
`endif
      end
   end

   assign sram_data         = data_oe ? wdata : 'z;
   assign bus.m_readdata    = {NUM_MASTERS{readdata}};
   assign bus.m_waitrequest = waitreq;

endmodule

// File: tb/tb_sram_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_sram_arb_rr
// Directed bench for sram_arb_rr with three masters and one wait cycle,
// attached to a small behavioural asynchronous SRAM (256 words, initialised
// to 0xFFFF, byte-selectable writes while ce_n and we_n are low).
// ---------------------------------------------------------------------------
module tb_sram_arb_rr;

   localparam int ADDR_WIDTH  = 20;
   localparam int DATA_WIDTH  = 16;
   localparam int BE_WIDTH    = 2;
   localparam int NUM_MASTERS = 3;
   localparam int WAIT_CYCLES = 1;

   logic                  clock;
   logic                  reset;
   logic [ADDR_WIDTH-1:0] sram_address;
   wire  [DATA_WIDTH-1:0] sram_data;
   logic                  sram_ce_n;
   logic                  sram_oe_n;
   logic                  sram_we_n;
   logic [BE_WIDTH-1:0]   sram_be_n;

   logic [15:0] mem [0:255];

   int          check_count;
   int          pass_count;
   int          g;
   logic [2:0]  exp_wait;
   logic [15:0] exp_rd   [3];
   logic [19:0] exp_addr [3];

   sram_arb_rr_if #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BE_WIDTH   (BE_WIDTH),
      .NUM_MASTERS(NUM_MASTERS)
   ) tb_bus ();

   sram_arb_rr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BE_WIDTH   (BE_WIDTH),
      .NUM_MASTERS(NUM_MASTERS),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (tb_bus),
      .sram_address(sram_address),
      .sram_data   (sram_data),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n),
      .sram_be_n   (sram_be_n)
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural SRAM: drives the bus whenever selected with output enable,
   // and stores the selected bytes on each clock while a write strobe is on.
   assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_address[7:0]] : 16'bz;

   always @(posedge clock) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_be_n[0]) mem[sram_address[7:0]][7:0]  <= sram_data[7:0];
         if (!sram_be_n[1]) mem[sram_address[7:0]][15:8] <= sram_data[15:8];
      end
   end

   // Set the request fields of one master's slice.
   task automatic applyStimulus(input int m, input logic rd, input logic wr,
                                input logic [19:0] addr, input logic [15:0] data,
                                input logic [1:0] be);
      tb_bus.m_read[m]                 = rd;
      tb_bus.m_write[m]                = wr;
      tb_bus.m_address[m*20 +: 20]     = addr;
      tb_bus.m_writedata[m*16 +: 16]   = data;
      tb_bus.m_byteenable[m*2 +: 2]    = be;
   endtask

   // One comparison; a miss is counted by leaving pass_count behind.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      g           = 0;
      exp_wait    = '1;
      exp_rd[0]   = 16'hA5C3;  exp_addr[0] = 20'h00010;
      exp_rd[1]   = 16'hFF34;  exp_addr[1] = 20'h00020;
      exp_rd[2]   = 16'h5A5A;  exp_addr[2] = 20'h00030;
      for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
      tb_bus.m_read        = '0;
      tb_bus.m_write       = '0;
      tb_bus.m_address     = '0;
      tb_bus.m_writedata   = '0;
      tb_bus.m_byteenable  = '0;
`ifdef SRAM_ARB_LOCK_EN
      tb_bus.m_lock        = '0;
`endif
      reset = 1'b1;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      checkOutput("rst_ce_n",  64'(sram_ce_n), 64'd1);
      checkOutput("rst_oe_n",  64'(sram_oe_n), 64'd1);
      checkOutput("rst_we_n",  64'(sram_we_n), 64'd1);
      checkOutput("rst_be_n",  64'(sram_be_n), 64'h3);
      checkOutput("rst_addr",  64'(sram_address), 64'h0);
      checkOutput("rst_wait",  64'(tb_bus.m_waitrequest), 64'h7);
      checkOutput("rst_rdata", 64'(tb_bus.m_readdata), 64'h0);
      reset = 1'b0;

      // Write 0xA5C3 to 0x10 from master 0
      @(negedge clock);
      applyStimulus(0, 1'b0, 1'b1, 20'h00010, 16'hA5C3, 2'b11);
      @(negedge clock);
      checkOutput("wr_c1_ce_n", 64'(sram_ce_n), 64'd0);
      checkOutput("wr_c1_we_n", 64'(sram_we_n), 64'd0);
      checkOutput("wr_c1_oe_n", 64'(sram_oe_n), 64'd1);
      checkOutput("wr_c1_addr", 64'(sram_address), 64'h10);
      checkOutput("wr_c1_be_n", 64'(sram_be_n), 64'h0);
      checkOutput("wr_c1_data", 64'(sram_data), 64'hA5C3);
      checkOutput("wr_c1_wait", 64'(tb_bus.m_waitrequest), 64'h7);
      @(negedge clock);
      checkOutput("wr_c2_we_n", 64'(sram_we_n), 64'd0);
      checkOutput("wr_c2_wait", 64'(tb_bus.m_waitrequest), 64'h7);
      @(negedge clock);
      checkOutput("wr_c3_we_n", 64'(sram_we_n), 64'd1);
      checkOutput("wr_c3_ce_n", 64'(sram_ce_n), 64'd1);
      checkOutput("wr_c3_wait", 64'(tb_bus.m_waitrequest), 64'h6);
      checkOutput("wr_c3_hold", 64'(sram_data), 64'hA5C3);
      applyStimulus(0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
      @(negedge clock);
      checkOutput("wr_c4_wait", 64'(tb_bus.m_waitrequest), 64'h7);

      // Read it back on master 0
      applyStimulus(0, 1'b1, 1'b0, 20'h00010, 16'h0, 2'b11);
      @(negedge clock);
      checkOutput("rd_c1_oe_n", 64'(sram_oe_n), 64'd0);
      checkOutput("rd_c1_we_n", 64'(sram_we_n), 64'd1);
      @(negedge clock);
      @(negedge clock);
      checkOutput("rd_c3_wait",  64'(tb_bus.m_waitrequest), 64'h6);
      checkOutput("rd_c3_rdata", 64'(tb_bus.m_readdata), 64'hA5C3_A5C3_A5C3);
      applyStimulus(0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
      @(negedge clock);

      // Low byte only: 0x1234 over 0xFFFF at 0x20, then read back
      applyStimulus(0, 1'b0, 1'b1, 20'h00020, 16'h1234, 2'b01);
      @(negedge clock);
      checkOutput("be_c1_be_n", 64'(sram_be_n), 64'h2);
      @(negedge clock);
      checkOutput("be_c2_be_n", 64'(sram_be_n), 64'h2);
      @(negedge clock);
      applyStimulus(0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
      @(negedge clock);
      applyStimulus(0, 1'b1, 1'b0, 20'h00020, 16'h0, 2'b11);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      checkOutput("be_rd_rdata", 64'(tb_bus.m_readdata[15:0]), 64'hFF34);
      applyStimulus(0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
      @(negedge clock);

      // Read and write together on master 1 behave as a write
      applyStimulus(1, 1'b1, 1'b1, 20'h00030, 16'h5A5A, 2'b11);
      @(negedge clock);
      checkOutput("rw_c1_oe_n", 64'(sram_oe_n), 64'd1);
      checkOutput("rw_c1_we_n", 64'(sram_we_n), 64'd0);
      checkOutput("rw_c1_data", 64'(sram_data), 64'h5A5A);
      @(negedge clock);
      @(negedge clock);
      checkOutput("rw_c3_wait", 64'(tb_bus.m_waitrequest), 64'h5);
      applyStimulus(1, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
      @(negedge clock);

      // Reset in the second ACCESS cycle of a master 2 write
      applyStimulus(2, 1'b0, 1'b1, 20'h00040, 16'h0F0F, 2'b11);
      @(negedge clock);
      checkOutput("ab_c1_ce_n", 64'(sram_ce_n), 64'd0);
      @(negedge clock);
      checkOutput("ab_c2_we_n", 64'(sram_we_n), 64'd0);
      reset = 1'b1;
      #1;
      checkOutput("ab_ce_n", 64'(sram_ce_n), 64'd1);
      checkOutput("ab_we_n", 64'(sram_we_n), 64'd1);
      checkOutput("ab_oe_n", 64'(sram_oe_n), 64'd1);
      checkOutput("ab_be_n", 64'(sram_be_n), 64'h3);
      checkOutput("ab_wait", 64'(tb_bus.m_waitrequest), 64'h7);
      applyStimulus(2, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("ab_post_wait", 64'(tb_bus.m_waitrequest), 64'h7);
      checkOutput("ab_post_ce_n", 64'(sram_ce_n), 64'd1);

      // Full contention: three continuous readers, grants 0,1,2,0,1,2 with an
      // acknowledge every fourth cycle
      applyStimulus(0, 1'b1, 1'b0, exp_addr[0], 16'h0, 2'b11);
      applyStimulus(1, 1'b1, 1'b0, exp_addr[1], 16'h0, 2'b11);
      applyStimulus(2, 1'b1, 1'b0, exp_addr[2], 16'h0, 2'b11);
      for (int n = 1; n <= 23; n++) begin
         @(negedge clock);
         g = (n / 4) % 3;
         exp_wait = (n % 4 == 3) ? ~(3'b001 << g) : 3'b111;
         checkOutput($sformatf("cont_wait_%0d", n), 64'(tb_bus.m_waitrequest), 64'(exp_wait));
         if (n % 4 == 1) begin
            checkOutput($sformatf("cont_addr_%0d", n), 64'(sram_address), 64'(exp_addr[g]));
         end
         if (n % 4 == 3) begin
            checkOutput($sformatf("cont_rdata_%0d", n), 64'(tb_bus.m_readdata[15:0]), 64'(exp_rd[g]));
         end
      end
      tb_bus.m_read = '0;
      @(negedge clock);
      checkOutput("cont_end_wait", 64'(tb_bus.m_waitrequest), 64'h7);
      @(negedge clock);
      checkOutput("cont_end_ce_n", 64'(sram_ce_n), 64'd1);

`ifdef SRAM_ARB_LOCK_EN
      // Master 1 locks for three transactions while master 0 waits
      applyStimulus(1, 1'b0, 1'b1, 20'h00050, 16'h0001, 2'b11);
      tb_bus.m_lock[1] = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         @(negedge clock);
         if (n == 1) applyStimulus(0, 1'b1, 1'b0, 20'h00010, 16'h0, 2'b11);
         exp_wait = (n == 3 || n == 7 || n == 11) ? 3'b101 : (n == 15) ? 3'b110 : 3'b111;
         checkOutput($sformatf("lock_wait_%0d", n), 64'(tb_bus.m_waitrequest), 64'(exp_wait));
         if (n == 11) begin
            applyStimulus(1, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
            tb_bus.m_lock[1] = 1'b0;
         end
      end
      applyStimulus(0, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
      @(negedge clock);
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
